shared_memory_responder: RTL and testbench
==========================================

SHARED_MEMORY_RESPONDER -- requirements
Module: shared_memory_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 10, word-index bits of the RAM (1024 words).
- LED_WIDTH, 6, LED register width.
- MMIO_BASE, 32'hFFFF_FF00, LED register address; MMIO_BASE+4 is the button address.
- DEBOUNCE_CYCLES, 16'd50000, stable cycles required before the button state changes.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- dataMemoryReadEnable, in, 1, data load request this cycle.
- dataMemoryWriteEnable, in, 1, data store request this cycle.
- dataMemoryAddress, in, 32, byte address of the data access.
- dataMemoryDataIn, in, 32, store data.
- dataMemoryDataOut, out, 32, load data.
- instructionMemoryAddress, in, 32, fetch byte address.
- instructionMemoryDataOut, out, 32, fetched instruction.
- instructionMemorySuccess, out, 1, instructionMemoryDataOut is valid for the current fetch address.
- button, in, 1, raw asynchronous push-button.
- led, out, LED_WIDTH, LED register contents.

Function
REQ-003 Decode: the RAM word index SHALL be addr[ADDR_WIDTH+1:2]; bits [1:0] are ignored; higher RAM bits wrap modulo 2^ADDR_WIDTH.
REQ-004 MMIO: a data address equal to MMIO_BASE or MMIO_BASE+4 SHALL select MMIO and SHALL never touch the RAM.
REQ-005 A data load SHALL be combinational, so dataMemoryDataOut is valid in the same cycle. Sources:
- RAM word.
- {zero-extend, led} at MMIO_BASE.
- {31'b0, buttonState} at MMIO_BASE+4.
REQ-006 dataMemoryDataOut SHALL be 0 when dataMemoryReadEnable is 0.
REQ-007 A data store SHALL commit at the rising edge ending the request cycle. A load of the same address in that cycle returns the old value.
REQ-008 A store to MMIO_BASE SHALL load led with dataMemoryDataIn[LED_WIDTH-1:0]. A store to MMIO_BASE+4 is ignored.
REQ-009 RAM port arbitration: the single RAM port SHALL serve a RAM-targeted data access (read or write) in preference to instruction fetch. MMIO data accesses do not occupy the port.
REQ-010 Fetch buffer state: fetchBuffer (32), fetchIndex (ADDR_WIDTH), fetchValid (1).
REQ-011 Fetch buffer update: in any cycle where the port is free, at the edge the buffer SHALL load:
- fetchBuffer <= RAM[fetch index];
- fetchIndex <= fetch index;
- fetchValid <= 1.
REQ-012 Success rule: instructionMemorySuccess SHALL equal fetchValid && (fetchIndex == current fetch index), combinationally.
REQ-013 Latency: a new fetch address SHALL see success exactly 1 cycle after the first port-free cycle. Sustained sequential throughput is one instruction per 2 cycles.
REQ-014 instructionMemoryDataOut SHALL equal fetchBuffer whenever success is 1, and 32'h00000013 (NOP) otherwise.
REQ-015 Coherence: a RAM store whose index equals fetchIndex SHALL clear fetchValid at that edge. A refill cannot happen in that cycle, because the port is busy.
REQ-016 Button: button SHALL pass a 2-flop synchronizer before any use. buttonState is the synchronized (optionally debounced) level.

Reset
REQ-017 With rst high at an edge, the following SHALL be cleared, and all outputs hold these values from the next cycle:
- fetchValid=0, fetchBuffer=32'h00000013, fetchIndex=0;
- led=0, synchronizer flops=0, buttonState=0, debounce counter=0.
REQ-018 RAM contents SHALL NOT be reset. A store or fetch presented during a reset cycle SHALL be discarded.

Configuration
REQ-019 Macro BUTTON_DEBOUNCE_EN SHALL control debouncing.
- Defined: buttonState changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count at 0.
- Undefined: buttonState is the synchronizer output directly (latency 2 cycles) and no counter is built.

Structure
REQ-020 A shared package mem_responder_pkg SHALL hold:
- MMIO_BASE default, BUTTON_OFFSET (4), NOP_INSTRUCTION (32'h00000013);
- the data-target enum {TARGET_RAM, TARGET_LED, TARGET_BUTTON}.
REQ-021 Synchronizer and debounce SHALL live in one sub-module, button_debouncer.

Verification
REQ-022 Fetch hit: after reset, present fetch 0x8 for 2 cycles with no data access -> success 0 in cycle 1, success 1 with RAM[2] in cycle 2.
REQ-023 Arbitration: hold fetch 0x10 with a RAM load at 0x40 for 3 cycles, then release -> success stays 0 and dataMemoryDataOut=RAM[16] each cycle; success=1 one cycle after release.
REQ-024 Self-modify: buffer holds 0x10 valid; store 0xDEADBEEF to 0x10 -> success drops next cycle, then returns 0xDEADBEEF.
REQ-025 MMIO: store 0x3F to MMIO_BASE -> led=6'h3F next cycle, and a load of MMIO_BASE returns 0x3F; a simultaneous fetch hit is unaffected.
REQ-026 Button, with BUTTON_DEBOUNCE_EN and DEBOUNCE_CYCLES=4:
- 3-cycle pulse -> button read stays 0;
- 10-cycle hold -> button read becomes 1 after 2+4 cycles.
REQ-027 Reset mid-operation: assert rst during a store to 0x20 -> RAM[8] unchanged, led=0, success=0 in the next cycle.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared constants, data-target decode and helper for the shared memory responder.
package mem_responder_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;
    localparam logic [31:0] BUTTON_OFFSET     = 32'd4;
    localparam logic [31:0] NOP_INSTRUCTION   = 32'h0000_0013;

    typedef enum logic [1:0] {
        TARGET_RAM,
        TARGET_LED,
        TARGET_BUTTON
    } data_target_t;

    function automatic data_target_t decode_target(input logic [31:0] addr,
                                                   input logic [31:0] base);
        if (addr == base) begin
            return TARGET_LED;
        end else if (addr == base + BUTTON_OFFSET) begin
            return TARGET_BUTTON;
        end
        return TARGET_RAM;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer for the raw push-button plus optional debounce filter.
// Debounce is built only when BUTTON_DEBOUNCE_EN is defined.
module button_debouncer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic state
);

    logic sync_meta;
    logic sync_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= button;
            sync_out  <= sync_meta;
        end
    end

`ifdef BUTTON_DEBOUNCE_EN
    logic [15:0] count;

    // Flip only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            state <= 1'b0;
        end else if (sync_out == state) begin
            count <= '0;
        end else if (count + 16'd1 >= DEBOUNCE_CYCLES) begin
            state <= sync_out;
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
    assign state = sync_out;
`endif

endmodule

// File: rtl/shared_memory_responder.sv
// Single-port RAM shared by data and instruction fetch, with LED/button MMIO.
// Button debouncing is enabled by defining BUTTON_DEBOUNCE_EN.
module shared_memory_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned LED_WIDTH       = 6,
    parameter logic [31:0] MMIO_BASE       = MMIO_BASE_DEFAULT,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dataMemoryReadEnable,
    input  logic                 dataMemoryWriteEnable,
    input  logic [31:0]          dataMemoryAddress,
    input  logic [31:0]          dataMemoryDataIn,
    output logic [31:0]          dataMemoryDataOut,
    input  logic [31:0]          instructionMemoryAddress,
    output logic [31:0]          instructionMemoryDataOut,
    output logic                 instructionMemorySuccess,
    input  logic                 button,
    output logic [LED_WIDTH-1:0] led
);

    localparam int unsigned RAM_WORDS = 1 << ADDR_WIDTH;

    logic [31:0]           ram [RAM_WORDS];
    logic [31:0]           fetch_buffer;
    logic [ADDR_WIDTH-1:0] fetch_index_q;
    logic                  fetch_valid;
    logic                  button_state;

    data_target_t          target;
    logic [ADDR_WIDTH-1:0] data_index;
    logic [ADDR_WIDTH-1:0] fetch_index;
    logic                  port_busy;
    logic                  ram_store;
    logic                  unused_fetch_bits;

    assign target      = decode_target(dataMemoryAddress, MMIO_BASE);
    assign data_index  = dataMemoryAddress[ADDR_WIDTH+1:2];
    assign fetch_index = instructionMemoryAddress[ADDR_WIDTH+1:2];
    assign unused_fetch_bits = ^{instructionMemoryAddress[31:ADDR_WIDTH+2],
                                 instructionMemoryAddress[1:0]};

    // MMIO accesses leave the RAM port to the fetch path.
    assign port_busy = (dataMemoryReadEnable || dataMemoryWriteEnable) && (target == TARGET_RAM);
    assign ram_store = dataMemoryWriteEnable && (target == TARGET_RAM) && !rst;

    always_comb begin
        dataMemoryDataOut = '0;
        if (dataMemoryReadEnable) begin
            case (target)
                TARGET_LED:    dataMemoryDataOut = 32'(led);
                TARGET_BUTTON: dataMemoryDataOut = {31'b0, button_state};
                default:       dataMemoryDataOut = ram[data_index];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_store) begin
            ram[data_index] <= dataMemoryDataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid   <= 1'b0;
            fetch_buffer  <= NOP_INSTRUCTION;
            fetch_index_q <= '0;
            led           <= '0;
        end else begin
            if (dataMemoryWriteEnable && (target == TARGET_LED)) begin
                led <= dataMemoryDataIn[LED_WIDTH-1:0];
            end
            // A store over the buffered word invalidates it; the port is busy so no refill.
            if (ram_store && (data_index == fetch_index_q)) begin
                fetch_valid <= 1'b0;
            end else if (!port_busy) begin
                fetch_buffer  <= ram[fetch_index];
                fetch_index_q <= fetch_index;
                fetch_valid   <= 1'b1;
            end
        end
    end

    assign instructionMemorySuccess = fetch_valid && (fetch_index_q == fetch_index);
    assign instructionMemoryDataOut = instructionMemorySuccess ? fetch_buffer : NOP_INSTRUCTION;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .state (button_state)
    );

endmodule

// File: tb/tb_shared_memory_responder.sv
// Directed self-checking bench for shared_memory_responder (fetch, arbitration, MMIO, button, reset).
module tb_shared_memory_responder;

    localparam logic [31:0] MMIO = 32'hFFFF_FF00;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        re;
    logic        we;
    logic [31:0] daddr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] iaddr;
    logic [31:0] iout;
    logic        isucc;
    logic        button;
    logic [5:0]  led;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] ram8_expected;

    always #5 clk = ~clk;

    shared_memory_responder #(
        .ADDR_WIDTH     (10),
        .LED_WIDTH      (6),
        .MMIO_BASE      (MMIO),
        .DEBOUNCE_CYCLES(16'd4)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .dataMemoryReadEnable    (re),
        .dataMemoryWriteEnable   (we),
        .dataMemoryAddress       (daddr),
        .dataMemoryDataIn        (din),
        .dataMemoryDataOut       (dout),
        .instructionMemoryAddress(iaddr),
        .instructionMemoryDataOut(iout),
        .instructionMemorySuccess(isucc),
        .button                  (button),
        .led                     (led)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] pattern(input int idx);
        return 32'h5A00_0000 + 32'(idx) * 32'h0001_0101;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; re = 1'b0; daddr = a; din = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; daddr = '0; din = '0; iaddr = '0; button = 1'b0;
        step();
        step();

        // Reset state
        re = 1'b1; daddr = MMIO + 32'd4;
        look();
        check("rst_success", 32'(isucc), 32'd0);
        check("rst_iout", iout, NOP);
        check("rst_led", 32'(led), 32'd0);
        check("rst_button", dout, 32'd0);
        re = 1'b0;

        // Preload RAM
        rst = 1'b0;
        store(32'h08, pattern(2));
        store(32'h10, pattern(4));
        store(32'h20, pattern(8));
        store(32'h40, pattern(16));
        store(32'hF00, pattern(960));

        re = 1'b1; daddr = 32'h42;
        look();
        check("byte_offset_ignored", dout, pattern(16));
        daddr = 32'h1040;
        #1;
        check("index_wrap", dout, pattern(16));
        re = 1'b0;
        #1;
        check("load_gated", dout, 32'd0);

        // Store and load of the same address in one cycle
        we = 1'b1; re = 1'b1; daddr = 32'h20; din = 32'h1234_5678;
        look();
        check("store_load_old", dout, pattern(8));
        step();
        we = 1'b0;
        look();
        check("store_committed", dout, 32'h1234_5678);
        ram8_expected = 32'h1234_5678;
        re = 1'b0;

        // Fetch hit after reset
        rst = 1'b1; iaddr = 32'h08;
        step();
        rst = 1'b0;
        look();
        check("fetch_c1_success", 32'(isucc), 32'd0);
        check("fetch_c1_iout", iout, NOP);
        step();
        look();
        check("fetch_c2_success", 32'(isucc), 32'd1);
        check("fetch_c2_iout", iout, pattern(2));

        // Arbitration: RAM load holds off the fetch
        iaddr = 32'h10; re = 1'b1; daddr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            look();
            check("arb_success", 32'(isucc), 32'd0);
            check("arb_dout", dout, pattern(16));
            step();
        end
        re = 1'b0;
        look();
        check("arb_release_success", 32'(isucc), 32'd0);
        step();
        look();
        check("arb_after_success", 32'(isucc), 32'd1);
        check("arb_after_iout", iout, pattern(4));

        // Self-modifying store over the buffered word
        we = 1'b1; re = 1'b1; daddr = 32'h10; din = 32'hDEAD_BEEF;
        look();
        check("smc_old_load", dout, pattern(4));
        check("smc_store_cycle_success", 32'(isucc), 32'd1);
        step();
        we = 1'b0; re = 1'b0;
        look();
        check("smc_invalid_success", 32'(isucc), 32'd0);
        check("smc_invalid_iout", iout, NOP);
        step();
        look();
        check("smc_refill_success", 32'(isucc), 32'd1);
        check("smc_refill_iout", iout, 32'hDEAD_BEEF);

        // MMIO LED
        we = 1'b1; daddr = MMIO; din = 32'h3F;
        look();
        check("mmio_store_fetch_hit", 32'(isucc), 32'd1);
        step();
        we = 1'b0; re = 1'b1;
        look();
        check("led_value", 32'(led), 32'h3F);
        check("led_load", dout, 32'h3F);
        check("mmio_fetch_iout", iout, 32'hDEAD_BEEF);
        we = 1'b1; re = 1'b0; din = 32'hFFFF_FFC5;
        step();
        we = 1'b0;
        look();
        check("led_truncate", 32'(led), 32'h05);
        store(MMIO + 32'd4, 32'h1);
        re = 1'b1; daddr = MMIO + 32'd4;
        look();
        check("button_store_ignored", dout, 32'd0);
        check("led_after_button_store", 32'(led), 32'h05);
        daddr = 32'hF00;
        #1;
        check("mmio_no_ram_alias", dout, pattern(960));

        // Button
        daddr = MMIO + 32'd4;
`ifdef BUTTON_DEBOUNCE_EN
        button = 1'b1;
        for (int i = 0; i < 3; i++) step();
        button = 1'b0;
        for (int i = 0; i < 8; i++) begin
            look();
            check("button_pulse_filtered", dout, 32'd0);
            step();
        end
        button = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            look();
            check("button_hold", dout, (k >= 6) ? 32'd1 : 32'd0);
        end
`else
        button = 1'b1;
        step();
        look();
        check("button_sync_1", dout, 32'd0);
        step();
        look();
        check("button_sync_2", dout, 32'd1);
        button = 1'b0;
        step();
        step();
        look();
        check("button_release", dout, 32'd0);
`endif
        button = 1'b0;
        re = 1'b0;

        // Reset during a store
        we = 1'b1; daddr = 32'h20; din = 32'hBAD0_BAD0; rst = 1'b1;
        step();
        rst = 1'b0; we = 1'b0; re = 1'b1;
        look();
        check("rst_store_discarded", dout, ram8_expected);
        check("rst_mid_led", 32'(led), 32'd0);
        check("rst_mid_success", 32'(isucc), 32'd0);
        check("rst_mid_iout", iout, NOP);
        re = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
